co2_adc_sampler: RTL

Sensor-side front end that produces the 8-bit `CO2_level` consumed by the vehicular emissions monitor. It drives a 3-wire SPI-style ADC, shifts in one `SAMPLE_BITS` reading per conversion and rejects stuck-line readings. It averages `2**AVG_LOG2` good readings and publishes the result as a registered `CO2_level` with a one-cycle `level_valid` strobe. It also raises a sticky `sensor_fault` when the sensor line is stuck.

---
 rtl/co2_adc_sampler.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/co2_adc_sampler.sv
// co2_adc_sampler: drives a 3-wire SPI ADC and rejects stuck-line readings.
// Good readings are averaged into an 8-bit CO2 level; stuck runs raise a sticky fault.
module co2_adc_sampler #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned SAMPLE_BITS = 10,
    parameter int unsigned AVG_LOG2    = 2,
    parameter int unsigned SAMPLE_GAP  = 100,
    parameter int unsigned FAULT_RUN   = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_en,
    input  logic       adc_miso,
    output logic       adc_cs_n,
    output logic       adc_sclk,
    output logic [7:0] CO2_level,
    output logic       level_valid,
    output logic       sensor_fault
);

    localparam int unsigned ACC_W = SAMPLE_BITS + AVG_LOG2;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(SAMPLE_BITS);
    localparam int unsigned GAP_W = (SAMPLE_GAP > 1) ? $clog2(SAMPLE_GAP) : 1;
    localparam int unsigned CNT_W = AVG_LOG2 + 1;
    localparam int unsigned RUN_W = $clog2(FAULT_RUN + 1);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SHIFT,
        DESELECT,
        ACCUM,
        GAP
    } state_t;

    state_t state;
    state_t state_nx;

    logic [DIV_W-1:0]       div_cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic [GAP_W-1:0]       gap_cnt;
    logic [SAMPLE_BITS-1:0] shreg;
    logic [ACC_W-1:0]       acc;
    logic [ACC_W-1:0]       acc_sum;
    logic [CNT_W-1:0]       good_cnt;
    logic [RUN_W-1:0]       bad_run;

    logic cs_n_nx;
    logic sclk_nx;
    logic div_done;
    logic bit_last;
    logic gap_done;
    logic in_frame;
    logic sample_bad;
    logic avg_done;
    logic run_full;
    logic run_hit;

    always_comb begin
        div_done   = (div_cnt == DIV_W'(CLK_DIV - 1));
        bit_last   = (bit_cnt == BIT_W'(SAMPLE_BITS - 1));
        gap_done   = (gap_cnt == GAP_W'(SAMPLE_GAP - 1));
        in_frame   = (state == SELECT) || (state == SHIFT)
                  || (state == DESELECT);
        sample_bad = (shreg == '0) || (shreg == '1);
        acc_sum    = acc + ACC_W'(shreg);
        avg_done   = (good_cnt == CNT_W'((1 << AVG_LOG2) - 1));
        run_full   = (bad_run == RUN_W'(FAULT_RUN));
        run_hit    = (bad_run >= RUN_W'(FAULT_RUN - 1));
    end

    // Pins are registered from the next state so they never glitch.
    always_comb begin
        state_nx = state;
        sclk_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_en) state_nx = SELECT;
            end
            SELECT: begin
                if (div_done) begin
                    state_nx = SHIFT;
                    sclk_nx  = 1'b1;
                end
            end
            SHIFT: begin
                sclk_nx = adc_sclk;
                if (div_done) begin
                    sclk_nx = !adc_sclk && !bit_last;
                    if (!adc_sclk && bit_last) state_nx = DESELECT;
                end
            end
            DESELECT: begin
                if (div_done) state_nx = ACCUM;
            end
            ACCUM: begin
                state_nx = GAP;
            end
            GAP: begin
                if (gap_done) state_nx = start_en ? SELECT : IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        cs_n_nx = !((state_nx == SELECT) || (state_nx == SHIFT)
                 || (state_nx == DESELECT));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            adc_cs_n <= 1'b1;
            adc_sclk <= 1'b0;
        end else begin
            state    <= state_nx;
            adc_cs_n <= cs_n_nx;
            adc_sclk <= sclk_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            shreg   <= '0;
        end else begin
            if (in_frame) begin
                div_cnt <= div_done ? '0 : div_cnt + 1'b1;
            end else begin
                div_cnt <= '0;
            end
            if (state == SHIFT && div_done && !adc_sclk) begin
                bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
            end
            // MISO is taken on the edge that ends each high phase.
            if (state == SHIFT && div_done && adc_sclk) begin
                shreg <= {shreg[SAMPLE_BITS-2:0], adc_miso};
            end
            if (state == GAP && !gap_done) begin
                gap_cnt <= gap_cnt + 1'b1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc          <= '0;
            good_cnt     <= '0;
            bad_run      <= '0;
            CO2_level    <= '0;
            level_valid  <= 1'b0;
            sensor_fault <= 1'b0;
        end else begin
            level_valid <= 1'b0;
            if (state == ACCUM) begin
                if (sample_bad) begin
                    if (!run_full) bad_run <= bad_run + 1'b1;
                    if (run_hit) sensor_fault <= 1'b1;
                end else begin
                    bad_run <= '0;
                    if (avg_done) begin
                        // Top 8 bits of the sum = average scaled to 8 bits.
                        CO2_level   <= acc_sum[ACC_W-1 -: 8];
                        level_valid <= 1'b1;
                        acc         <= '0;
                        good_cnt    <= '0;
                    end else begin
                        acc      <= acc_sum;
                        good_cnt <= good_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule
